// File: rtl/stream_fork.sv
// Forks one wide valid/ready stream into OUT_NB independent lanes, each backed by a DEPTH-entry FIFO.
// Latency: a word accepted at edge N is visible on every lane after edge N; in_rdy is registered.
// Backpressure: input accepted only when every lane has room; optional skew check under STREAM_FORK_SKEW_CHECK_EN.
module stream_fork #(
    parameter int WIDTH    = 32,
    parameter int OUT_NB   = 4,
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 4
) (
    input  logic                             clk,
    input  logic                             s_rst_n,
    input  logic [OUT_NB*WIDTH-1:0]          in_data,
    input  logic                             in_vld,
    output logic                             in_rdy,
    output logic [OUT_NB-1:0][WIDTH-1:0]     out_data,
    output logic [OUT_NB-1:0]                out_vld,
    input  logic [OUT_NB-1:0]                out_rdy,
    output logic                             error_skew
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (MAX_SKEW < 0 || MAX_SKEW > DEPTH) begin : g_bad_max_skew
        $error("stream_fork: MAX_SKEW must lie in 0..DEPTH");
    end

    logic                         push;
    logic [OUT_NB-1:0]            pop;
    logic [OUT_NB-1:0]            lane_ok;
    logic [OUT_NB-1:0][CW-1:0]    cnt_all;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    for (genvar i = 0; i < OUT_NB; i++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    cnt;
        logic [CW-1:0]    cnt_nxt;

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= in_data[i*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                end
                cnt <= cnt_nxt;
            end
        end

        // in_rdy only admits a push when every lane has room, so cnt never exceeds DEPTH
        assign cnt_nxt     = cnt + CW'(push) - CW'(pop[i]);
        assign lane_ok[i]  = cnt_nxt < CW'(DEPTH);
        assign out_vld[i]  = cnt != '0;
        assign out_data[i] = mem[rd_ptr];
        assign cnt_all[i]  = cnt;
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            in_rdy <= 1'b0;
        end else begin
            in_rdy <= &lane_ok;
        end
    end

`ifdef STREAM_FORK_SKEW_CHECK_EN
    logic [CW-1:0] cnt_max;
    logic [CW-1:0] cnt_min;

    always_comb begin
        cnt_max = cnt_all[0];
        cnt_min = cnt_all[0];
        for (int i = 1; i < OUT_NB; i++) begin
            if (cnt_all[i] > cnt_max) cnt_max = cnt_all[i];
            if (cnt_all[i] < cnt_min) cnt_min = cnt_all[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            error_skew <= 1'b0;
        end else if ((cnt_max - cnt_min) > CW'(MAX_SKEW)) begin
            error_skew <= 1'b1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_all;
    assign error_skew = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fork.sv
// Randomized bench for stream_fork checked against per-lane reference queues.
module tb_stream_fork;

    localparam int WIDTH    = 32;
    localparam int OUT_NB   = 4;
    localparam int DEPTH    = 4;
    localparam int MAX_SKEW = 2;

    logic                         clk = 1'b0;
    logic                         s_rst_n = 1'b0;
    logic [OUT_NB*WIDTH-1:0]      in_data = '0;
    logic                         in_vld = 1'b0;
    logic                         in_rdy;
    logic [OUT_NB-1:0][WIDTH-1:0] out_data;
    logic [OUT_NB-1:0]            out_vld;
    logic [OUT_NB-1:0]            out_rdy = '0;
    logic                         error_skew;

    stream_fork #(
        .WIDTH(WIDTH), .OUT_NB(OUT_NB), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .error_skew(error_skew)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [WIDTH-1:0]        q [OUT_NB][$];
    logic                    exp_rdy = 1'b0;
    logic                    exp_err = 1'b0;
    logic [OUT_NB*WIDTH-1:0] word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_word();
        for (int i = 0; i < OUT_NB; i++) word[i*WIDTH +: WIDTH] = $urandom;
    endtask

    // One clock cycle: drive, check registered outputs, advance the reference model.
    task automatic step(input logic rst_n, input logic vld, input logic [OUT_NB-1:0] rdy);
        int mx, mn;
        logic all_room;
        s_rst_n = rst_n;
        in_vld  = vld;
        out_rdy = rdy;
        in_data = word;
        #1;
        chk("in_rdy", in_rdy, exp_rdy);
        chk("error_skew", error_skew, exp_err);
        for (int i = 0; i < OUT_NB; i++) begin
            chk($sformatf("out_vld[%0d]", i), out_vld[i], q[i].size() != 0);
            if (q[i].size() != 0)
                chk($sformatf("out_data[%0d]", i), out_data[i], q[i][0]);
        end
        if (!rst_n) begin
            for (int i = 0; i < OUT_NB; i++) q[i].delete();
            exp_rdy = 1'b0;
            exp_err = 1'b0;
        end else begin
            mx = q[0].size();
            mn = q[0].size();
            for (int i = 1; i < OUT_NB; i++) begin
                if (q[i].size() > mx) mx = q[i].size();
                if (q[i].size() < mn) mn = q[i].size();
            end
`ifdef STREAM_FORK_SKEW_CHECK_EN
            if (mx - mn > MAX_SKEW) exp_err = 1'b1;
`endif
            for (int i = 0; i < OUT_NB; i++)
                if (rdy[i] && q[i].size() != 0) void'(q[i].pop_front());
            if (vld && exp_rdy) begin
                for (int i = 0; i < OUT_NB; i++) q[i].push_back(word[i*WIDTH +: WIDTH]);
                new_word();
            end
            all_room = 1'b1;
            for (int i = 0; i < OUT_NB; i++)
                if (q[i].size() >= DEPTH) all_room = 1'b0;
            exp_rdy = all_room;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        new_word();
        @(negedge clk);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, '1);

        // streaming at full rate
        for (int c = 0; c < 1000; c++) step(1'b1, 1'b1, '1);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, '1);

        // lane 0 stalled: four words fill it, then release
        for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'b1110);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 4'b1111);

        // lane 2 full, pop on lane 2 while input is held off
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 4'b1011);
        step(1'b1, 1'b1, 4'b0100);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 4'b0000);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 4'b1111);

        // reset with three words queued in every lane
        for (int c = 0; c < 4; c++) step(1'b1, c < 3, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0000);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 4'b1111);

        // lane 3 stalled while the others drain: skew grows past MAX_SKEW
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'b0000);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 4'b0111);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 4'b0000);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            logic [OUT_NB-1:0] r;
            for (int i = 0; i < OUT_NB; i++) r[i] = ($urandom_range(99) < 50);
            step(1'b1, $urandom_range(99) < 70, r);
        end
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, '1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
